// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencer with credit-limited imem requests and an instruction FIFO toward decode
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] start_pc,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = AW + 1;
  localparam logic [W:0] DEPTH_C = (W+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [W-1:0]  inflight_q, inflight_d;
  logic [W-1:0]  discard_q, discard_d;
  logic [W-1:0]  count_q, count_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pcs_q [DEPTH];
  logic          rsp, wr, rd, acc, start_flush;

  assign imem_req_valid = (state_q == RUN) && (({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = count_q != '0;
  assign instr_out      = instr_valid ? data_q[rptr_q] : '0;
  assign instr_pc       = instr_valid ? pcs_q[rptr_q] : '0;
  assign busy           = (state_q == RUN) || (inflight_q != '0);

  // Next state: normal fetch/FIFO bookkeeping, then start flush, then redirect overriding everything
  always_comb begin
    rsp         = imem_rsp_valid && inflight_q != '0;
    wr          = rsp && discard_q == '0;
    rd          = instr_valid && instr_ready;
    acc         = imem_req_valid && imem_req_ready;
    start_flush = start && state_q == IDLE;
    state_d     = start_flush ? RUN : (halt ? IDLE : state_q);
    pc_d        = acc ? pc_q + 32'd4 : pc_q;
    rsp_pc_d    = wr ? rsp_pc_q + 32'd4 : rsp_pc_q;
    inflight_d  = inflight_q + W'(acc) - W'(rsp);
    discard_d   = (rsp && discard_q != '0) ? discard_q - W'(1) : discard_q;
    count_d     = count_q + W'(wr) - W'(rd);
    wptr_d      = wr ? wptr_q + AW'(1) : wptr_q;
    rptr_d      = rd ? rptr_q + AW'(1) : rptr_q;
    if (start_flush) begin
      pc_d     = start_pc & 32'hFFFF_FFFC;
      rsp_pc_d = start_pc & 32'hFFFF_FFFC;
      count_d  = '0;
      wptr_d   = '0;
      rptr_d   = '0;
    end
    if (redirect_valid) begin
      pc_d      = redirect_pc & 32'hFFFF_FFFC;
      rsp_pc_d  = redirect_pc & 32'hFFFF_FFFC;
      discard_d = inflight_q - W'(rsp);
      count_d   = '0;
      wptr_d    = '0;
      rptr_d    = '0;
    end
  end

  // Control state registers; reset abandons every outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // FIFO storage holds instruction word and its PC; contents are only visible when count is nonzero
  always_ff @(posedge clk) begin
    if (wr) begin
      data_q[wptr_q] <= imem_rsp_data;
      pcs_q[wptr_q]  <= rsp_pc_q;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized and directed checks against a queue-based fetch model
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 0, rst_n = 0;
  logic        start = 0, halt = 0, redirect_valid = 0;
  logic [31:0] start_pc = 0, redirect_pc = 0;
  logic        imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic        instr_valid, instr_ready = 0;
  logic [31:0] instr_out, instr_pc;
  logic        busy;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .instr_pc(instr_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; bit drop;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;

  req_t        oq[$];
  ent_t        fq[$];
  bit          run = 0;
  logic [31:0] pc = RESET_PC;
  int          errors = 0, checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit st, input logic [31:0] spc, input bit hl, input bit rv,
                     input logic [31:0] rpc, input bit rdy, input bit rsp, input bit ird);
    bit   e_req, sflush;
    req_t r;
    @(negedge clk);
    start = st; start_pc = spc; halt = hl; redirect_valid = rv; redirect_pc = rpc;
    imem_req_ready = rdy; instr_ready = ird;
    imem_rsp_valid = rsp && oq.size() != 0;
    imem_rsp_data  = imem_rsp_valid ? mem_word(oq[0].addr) : $urandom;
    #1;
    e_req = run && (oq.size() + fq.size() < DEPTH) && !rv;
    check("req_valid", 32'(imem_req_valid), 32'(e_req));
    if (e_req) check("req_addr", imem_req_addr, pc);
    check("instr_valid", 32'(instr_valid), 32'(fq.size() != 0));
    check("instr_out", instr_out, fq.size() != 0 ? fq[0].data : 32'h0);
    check("instr_pc", instr_pc, fq.size() != 0 ? fq[0].pc : 32'h0);
    check("busy", 32'(busy), 32'(run || oq.size() != 0));
    sflush = st && !run;
    if (ird && fq.size() != 0) void'(fq.pop_front());
    if (imem_rsp_valid) begin
      r = oq.pop_front();
      if (!r.drop) fq.push_back('{r.addr, mem_word(r.addr)});
    end
    if (e_req && rdy) begin
      oq.push_back('{pc, 1'b0});
      pc = pc + 32'd4;
    end
    if (sflush) begin
      fq.delete();
      pc = {spc[31:2], 2'b00};
    end
    if (rv) begin
      fq.delete();
      foreach (oq[i]) oq[i].drop = 1'b1;
      pc = {rpc[31:2], 2'b00};
    end
    if (sflush) run = 1;
    else if (hl && run) run = 0;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_req"}, 32'(imem_req_valid), 32'h0);
    check({tag, "_ivalid"}, 32'(instr_valid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_iout"}, instr_out, 32'h0);
    check({tag, "_ipc"}, instr_pc, 32'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_check("rst");
    @(negedge clk) rst_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Streaming from 0x100 at full rate
    cyc(1, 32'h100, 0, 0, 0, 1, 1, 1);
    repeat (12) cyc(0, 0, 0, 0, 0, 1, 1, 1);
    // Decoder stalled: credits run out, then one read frees one request
    repeat (10) cyc(0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 1);
    repeat (4) cyc(0, 0, 0, 0, 0, 1, 1, 0);
    // Three requests in flight, then redirect to 0x200
    cyc(0, 0, 0, 1, 32'h300, 1, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 32'h200, 1, 0, 1);
    repeat (8) cyc(0, 0, 0, 0, 0, 1, 1, 1);
    // Redirect colliding with a response and a decoder read
    repeat (2) cyc(0, 0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 32'h240, 1, 1, 1);
    repeat (6) cyc(0, 0, 0, 0, 0, 1, 1, 1);
    // Halt with two requests in flight
    cyc(0, 0, 0, 1, 32'h400, 1, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 0, 0, 1, 1, 1);
    // Address wrap at the top of the space
    cyc(1, 32'hFFFF_FFF8, 0, 0, 0, 1, 1, 1);
    repeat (6) cyc(0, 0, 0, 0, 0, 1, 1, 1);
    cyc(0, 0, 1, 0, 0, 1, 1, 1);
    repeat (6) cyc(0, 0, 0, 0, 0, 1, 1, 1);
    // Random traffic with starts, halts and redirects
    for (int n = 0; n < 3000; n++)
      cyc(oq.size() == 0 && $urandom_range(0, 15) == 0, $urandom,
          $urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0, $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    // Reset in the middle of traffic
    if (oq.size() == 0) cyc(1, 32'h800, 0, 0, 0, 1, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 0; start = 0; halt = 0; redirect_valid = 0; imem_rsp_valid = 0; imem_req_ready = 0; instr_ready = 0;
    #1;
    reset_check("midrst");
    oq.delete(); fq.delete(); run = 0; pc = RESET_PC;
    @(negedge clk) rst_n = 1;
    cyc(1, 32'h500, 0, 0, 0, 1, 1, 1);
    repeat (8) cyc(0, 0, 0, 0, 0, 1, 1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
